iibg_ctrl_19x19: RTL and testbench

Sequencer for the 19x19 integral-image BRAM group (20x20 = 400 words of 21 bits).
- Per window: resets the group, then streams 400 integral words into it.
- Per feature: clears the eight 84-bit group outputs, then issues eight rectangle reads. Each read is a rdreq pulse followed by four corner addresses.
- Signals the downstream classifier when all eight groups hold valid corner data.

---
 rtl/iibg_pkg.sv | 38 +++
 rtl/iibg_corner_addr.sv | 49 ++++
 rtl/iibg_ctrl_19x19.sv | 233 +++++++++++++++++++++++
 tb/tb_iibg_ctrl_19x19.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iibg_pkg.sv
// Shared sizes, state encoding and the row-pitch address helper for the
// 19x19 integral-image BRAM group sequencer.
package iibg_pkg;

  localparam int IMG_W    = 20;
  localparam int N_WORDS  = 400;
  localparam int N_GROUPS = 8;
  localparam int WORD_W   = 21;
  localparam int ADDR_W   = 9;
  localparam int RECT_W   = 5;
  localparam int RD_GAP   = 7;

  localparam logic [RECT_W-1:0] COORD_MAX = RECT_W'(IMG_W - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_H,
    ST_LOAD,
    ST_F_CLR,
    ST_R_WAIT,
    ST_R_REQ,
    ST_R_ADDR,
    ST_R_GAP,
    ST_FEAT,
    ST_DONE
  } state_e;

  // row*20 + col as (row<<4)+(row<<2)+col; operands are already clamped to 19.
  function automatic logic [ADDR_W-1:0] row_col_addr(input logic [RECT_W-1:0] row,
                                                      input logic [RECT_W-1:0] col);
    logic [ADDR_W-1:0] row_w;
    logic [ADDR_W-1:0] col_w;
    row_w = {4'd0, row};
    col_w = {4'd0, col};
    return (row_w << 3'd4) + (row_w << 3'd2) + col_w;
  endfunction

endpackage

// File: rtl/iibg_corner_addr.sv
// Rectangle descriptor to the four corner word addresses A,B,C,D, with every
// coordinate saturated to the last row/column and an out-of-range flag.
module iibg_corner_addr
  import iibg_pkg::*;
(
  input  logic [RECT_W-1:0] x,
  input  logic [RECT_W-1:0] y,
  input  logic [RECT_W-1:0] w,
  input  logic [RECT_W-1:0] h,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] addr_c,
  output logic [ADDR_W-1:0] addr_d,
  output logic              oor
);

  logic [RECT_W:0]   x_end_s;
  logic [RECT_W:0]   y_end_s;
  logic              x_oor_s;
  logic              y_oor_s;
  logic [RECT_W-1:0] col_l_s;
  logic [RECT_W-1:0] col_r_s;
  logic [RECT_W-1:0] row_t_s;
  logic [RECT_W-1:0] row_b_s;

  // Far edges and saturation of all four coordinates.
  always_comb begin
    x_end_s = {1'b0, x} + {1'b0, w};
    y_end_s = {1'b0, y} + {1'b0, h};
    x_oor_s = (x_end_s > {1'b0, COORD_MAX});
    y_oor_s = (y_end_s > {1'b0, COORD_MAX});

    if (x > COORD_MAX) col_l_s = COORD_MAX;
    else               col_l_s = x;
    if (y > COORD_MAX) row_t_s = COORD_MAX;
    else               row_t_s = y;
    if (x_oor_s) col_r_s = COORD_MAX;
    else         col_r_s = x_end_s[RECT_W-1:0];
    if (y_oor_s) row_b_s = COORD_MAX;
    else         row_b_s = y_end_s[RECT_W-1:0];
  end

  assign addr_a = row_col_addr(row_t_s, col_l_s);
  assign addr_b = row_col_addr(row_t_s, col_r_s);
  assign addr_c = row_col_addr(row_b_s, col_l_s);
  assign addr_d = row_col_addr(row_b_s, col_r_s);
  assign oor    = x_oor_s | y_oor_s;

endmodule

// File: rtl/iibg_ctrl_19x19.sv
// Sequencer for the 19x19 integral-image BRAM group: per window reset + 400-word
// load, per feature an output clear followed by eight four-corner rectangle reads.
module iibg_ctrl_19x19
  import iibg_pkg::*;
(
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iStart,
  input  logic              iPix_valid,
  input  logic [WORD_W-1:0] iPix_data,
  output logic              oPix_ready,
  input  logic              iRect_valid,
  input  logic [RECT_W-1:0] iRect_x,
  input  logic [RECT_W-1:0] iRect_y,
  input  logic [RECT_W-1:0] iRect_w,
  input  logic [RECT_W-1:0] iRect_h,
  input  logic              iRect_eow,
  output logic              oRect_ready,
  output logic              oIibg_rst,
  output logic              oIibg_wrreq,
  output logic [WORD_W-1:0] oIibg_data,
  output logic [ADDR_W-1:0] oIibg_addr,
  output logic              oIibg_rdreq,
  output logic              oIibg_full,
  input  logic              iIibg_full,
  output logic              oBusy,
  output logic              oFeat_valid,
  output logic              oWin_done,
  output logic              oErr
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);
  localparam logic [3:0]        GAP_EXIT  = 4'(RD_GAP - 2);
  localparam logic [3:0]        LAST_RECT = 4'(N_GROUPS - 1);

  state_e            state_r;
  logic [1:0]        sub_r;
  logic [ADDR_W-1:0] wcnt_r;
  logic [3:0]        rcnt_r;
  logic [3:0]        gcnt_r;
  logic              eow_r;
  logic [ADDR_W-1:0] corner_a_r;
  logic [ADDR_W-1:0] corner_b_r;
  logic [ADDR_W-1:0] corner_c_r;
  logic [ADDR_W-1:0] corner_d_r;
  logic              pix_ready_r;
  logic              rect_ready_r;
  logic              rst_r;
  logic              full_r;
  logic              rdreq_r;
  logic [ADDR_W-1:0] addr_r;
  logic              feat_r;
  logic              done_r;
  logic              busy_r;
  logic              err_r;

  logic              pix_hs_s;
  logic              rect_hs_s;
  logic [ADDR_W-1:0] corner_a_s;
  logic [ADDR_W-1:0] corner_b_s;
  logic [ADDR_W-1:0] corner_c_s;
  logic [ADDR_W-1:0] corner_d_s;
  logic              oor_s;

  iibg_corner_addr u_corner (
    .x      (iRect_x),
    .y      (iRect_y),
    .w      (iRect_w),
    .h      (iRect_h),
    .addr_a (corner_a_s),
    .addr_b (corner_b_s),
    .addr_c (corner_c_s),
    .addr_d (corner_d_s),
    .oor    (oor_s)
  );

  assign pix_hs_s  = iPix_valid & pix_ready_r;
  assign rect_hs_s = iRect_valid & rect_ready_r;

  // Main sequencer; every control output is a register written only here.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_r      <= ST_IDLE;
      sub_r        <= 2'd0;
      wcnt_r       <= {ADDR_W{1'b0}};
      rcnt_r       <= 4'd0;
      gcnt_r       <= 4'd0;
      eow_r        <= 1'b0;
      corner_a_r   <= {ADDR_W{1'b0}};
      corner_b_r   <= {ADDR_W{1'b0}};
      corner_c_r   <= {ADDR_W{1'b0}};
      corner_d_r   <= {ADDR_W{1'b0}};
      pix_ready_r  <= 1'b0;
      rect_ready_r <= 1'b0;
      rst_r        <= 1'b0;
      full_r       <= 1'b0;
      rdreq_r      <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      feat_r       <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (iStart) begin
            state_r <= ST_RST_H;
            rst_r   <= 1'b1;
            busy_r  <= 1'b1;
            err_r   <= 1'b0;
            sub_r   <= 2'd0;
          end
        end
        ST_RST_H: begin
          if (sub_r == 2'd1) begin
            rst_r       <= 1'b0;
            pix_ready_r <= 1'b1;
            wcnt_r      <= {ADDR_W{1'b0}};
            state_r     <= ST_LOAD;
          end else begin
            sub_r <= sub_r + 2'd1;
          end
        end
        ST_LOAD: begin
          if (pix_hs_s) begin
            wcnt_r <= wcnt_r + 9'd1;
            if (wcnt_r == LAST_WORD) begin
              // The group must report its last address on this very write.
              if (!iIibg_full) err_r <= 1'b1;
              pix_ready_r <= 1'b0;
              full_r      <= 1'b1;
              rcnt_r      <= 4'd0;
              sub_r       <= 2'd0;
              state_r     <= ST_F_CLR;
            end
          end
        end
        ST_F_CLR: begin
          full_r <= 1'b0;
          if (sub_r == 2'd3) begin
            rect_ready_r <= 1'b1;
            state_r      <= ST_R_WAIT;
          end else begin
            sub_r <= sub_r + 2'd1;
          end
        end
        ST_R_WAIT: begin
          if (rect_hs_s) begin
            rect_ready_r <= 1'b0;
            corner_a_r   <= corner_a_s;
            corner_b_r   <= corner_b_s;
            corner_c_r   <= corner_c_s;
            corner_d_r   <= corner_d_s;
            eow_r        <= iRect_eow;
            if (oor_s) err_r <= 1'b1;
            rdreq_r      <= 1'b1;
            gcnt_r       <= 4'd0;
            state_r      <= ST_R_REQ;
          end
        end
        ST_R_REQ: begin
          rdreq_r <= 1'b0;
          addr_r  <= corner_a_r;
          sub_r   <= 2'd0;
          gcnt_r  <= gcnt_r + 4'd1;
          state_r <= ST_R_ADDR;
        end
        ST_R_ADDR: begin
          gcnt_r <= gcnt_r + 4'd1;
          sub_r  <= sub_r + 2'd1;
          case (sub_r)
            2'd0:    addr_r <= corner_b_r;
            2'd1:    addr_r <= corner_c_r;
            2'd2:    addr_r <= corner_d_r;
            default: begin
              addr_r  <= {ADDR_W{1'b0}};
              state_r <= ST_R_GAP;
            end
          endcase
        end
        ST_R_GAP: begin
          gcnt_r <= gcnt_r + 4'd1;
          // Leaving here at gap-2 puts the next rdreq exactly RD_GAP after this one.
          if (gcnt_r >= GAP_EXIT) begin
            rcnt_r <= rcnt_r + 4'd1;
            if (rcnt_r == LAST_RECT) begin
              feat_r  <= 1'b1;
              state_r <= ST_FEAT;
            end else begin
              rect_ready_r <= 1'b1;
              state_r      <= ST_R_WAIT;
            end
          end
        end
        ST_FEAT: begin
          feat_r <= 1'b0;
          if (eow_r) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            full_r  <= 1'b1;
            rcnt_r  <= 4'd0;
            sub_r   <= 2'd0;
            state_r <= ST_F_CLR;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign oPix_ready  = pix_ready_r;
  assign oRect_ready = rect_ready_r;
  assign oIibg_rst   = rst_r;
  assign oIibg_wrreq = pix_hs_s;
  assign oIibg_data  = pix_hs_s ? iPix_data : {WORD_W{1'b0}};
  assign oIibg_addr  = addr_r;
  assign oIibg_rdreq = rdreq_r;
  assign oIibg_full  = full_r;
  assign oBusy       = busy_r;
  assign oFeat_valid = feat_r;
  assign oWin_done   = done_r;
  assign oErr        = err_r;

endmodule

// File: tb/tb_iibg_ctrl_19x19.sv
// Scoreboard bench for iibg_ctrl_19x19 with a behavioural model of the BRAM group.
module tb_iibg_ctrl_19x19;

  logic        iClk = 1'b0;
  logic        iReset, iStart, iPix_valid, iRect_valid, iRect_eow;
  logic [20:0] iPix_data;
  logic [4:0]  iRect_x, iRect_y, iRect_w, iRect_h;
  logic        oPix_ready, oRect_ready, oIibg_rst, oIibg_wrreq, oIibg_rdreq, oIibg_full;
  logic [20:0] oIibg_data;
  logic [8:0]  oIibg_addr;
  logic        iIibg_full, oBusy, oFeat_valid, oWin_done, oErr;

  always #5 iClk = ~iClk;

  iibg_ctrl_19x19 dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart),
    .iPix_valid(iPix_valid), .iPix_data(iPix_data), .oPix_ready(oPix_ready),
    .iRect_valid(iRect_valid), .iRect_x(iRect_x), .iRect_y(iRect_y),
    .iRect_w(iRect_w), .iRect_h(iRect_h), .iRect_eow(iRect_eow), .oRect_ready(oRect_ready),
    .oIibg_rst(oIibg_rst), .oIibg_wrreq(oIibg_wrreq), .oIibg_data(oIibg_data),
    .oIibg_addr(oIibg_addr), .oIibg_rdreq(oIibg_rdreq), .oIibg_full(oIibg_full),
    .iIibg_full(iIibg_full), .oBusy(oBusy), .oFeat_valid(oFeat_valid),
    .oWin_done(oWin_done), .oErr(oErr)
  );

  logic [39:0] all_out;
  assign all_out = {oPix_ready, oRect_ready, oIibg_rst, oIibg_wrreq, oIibg_data, oIibg_addr,
                    oIibg_rdreq, oIibg_full, oBusy, oFeat_valid, oWin_done, oErr};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // x, y, w, h, then hand-computed A, B, C, D; rows 0-7 feature 1, rows 8-15 feature 2.
  int rt [0:15][0:7] = '{
    '{2, 3, 4, 5, 62, 66, 162, 166},
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{10, 10, 5, 5, 210, 215, 310, 315},
    '{0, 0, 19, 19, 0, 19, 380, 399},
    '{1, 2, 3, 0, 41, 44, 41, 44},
    '{7, 1, 0, 4, 27, 27, 107, 107},
    '{19, 19, 0, 0, 399, 399, 399, 399},
    '{4, 6, 8, 2, 124, 132, 164, 172},
    '{18, 1, 3, 2, 38, 39, 78, 79},
    '{0, 17, 0, 5, 340, 340, 380, 380},
    '{2, 3, 4, 5, 62, 66, 162, 166},
    '{5, 5, 1, 1, 105, 106, 125, 126},
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{10, 10, 5, 5, 210, 215, 310, 315},
    '{19, 19, 0, 0, 399, 399, 399, 399},
    '{4, 6, 8, 2, 124, 132, 164, 172}
  };

  logic [20:0] exp_wr[$];
  logic [8:0]  exp_addr[$];
  logic [83:0] exp_feat[$];

  // BRAM group model: held at address 0 while its reset request is high.
  logic [20:0] mem [0:399];
  logic [83:0] gdata [0:7];
  logic [8:0]  gaddr = 9'd0;
  int gidx = 0, gcur = 0, gphase = 0;
  assign iIibg_full = (gaddr == 9'd399);

  always @(posedge iClk) begin
    if (oIibg_rst) gaddr <= 9'd0;
    else if (oIibg_wrreq) begin
      mem[gaddr] <= oIibg_data;
      gaddr <= (gaddr == 9'd399) ? 9'd0 : gaddr + 9'd1;
    end
    if (oIibg_full) begin
      for (int i = 0; i < 8; i++) gdata[i] <= 84'd0;
      gidx <= 0;
      gphase <= 0;
    end else if (oIibg_rdreq) begin
      gcur <= gidx;
      gidx <= gidx + 1;
      gphase <= 1;
    end else if (gphase != 0) begin
      if (gcur < 8) gdata[gcur][(gphase-1)*21 +: 21] <= mem[oIibg_addr];
      gphase <= (gphase == 4) ? 0 : gphase + 1;
    end
  end

  logic rst_q = 1'b0;
  always @(posedge iClk) rst_q <= iReset;

  int rst_w = 0, aphase = 0, since_rd = -1, rd_in_feat = 0, feats_in_win = 0;
  int full_cnt = 0, done_cnt = 0;
  bit busy_chk = 1'b0;

  // Monitor: pops the scoreboard whenever the DUT presents an output event.
  always @(negedge iClk) begin
    if (rst_q) begin
      aphase = 0; exp_addr.delete(); rd_in_feat = 0; since_rd = -1;
      feats_in_win = 0; busy_chk = 1'b0;
    end
    if (oIibg_wrreq) begin
      if (exp_wr.size() != 0) check("wr_data", oIibg_data, exp_wr.pop_front());
      else check("wr_unexpected", oIibg_wrreq, 0);
    end
    if (oIibg_rst) rst_w++;
    else if (rst_w != 0) begin
      check("rst_width", rst_w, 2);
      rst_w = 0;
    end
    if (aphase != 0) begin
      check("corner_addr", oIibg_addr, (exp_addr.size() != 0) ? exp_addr.pop_front() : 9'd0);
      aphase = (aphase == 4) ? 0 : aphase + 1;
    end else check("addr_idle_zero", oIibg_addr, 0);
    if (since_rd >= 0) since_rd++;
    if (oIibg_rdreq) begin
      if (rd_in_feat != 0) check("rdreq_gap", since_rd, 7);
      rd_in_feat++;
      since_rd = 0;
      aphase = 1;
    end
    if (oIibg_full) begin
      rd_in_feat = 0;
      full_cnt++;
    end
    if (oFeat_valid) begin
      check("feat_after_rdreq", since_rd, 6);
      check("feat_nreads", rd_in_feat, 8);
      if (exp_feat.size() != 0) check("feat_data3", gdata[3], exp_feat.pop_front());
      else check("feat_unexpected", oFeat_valid, 0);
      feats_in_win++;
    end
    if (busy_chk) begin
      check("busy_fall", oBusy, 0);
      busy_chk = 1'b0;
    end
    if (oWin_done) begin
      check("done_feats", feats_in_win, 2);
      check("done_busy", oBusy, 1);
      feats_in_win = 0;
      busy_chk = 1'b1;
      done_cnt++;
    end
  end

  task automatic tick();
    @(negedge iClk);
  endtask

  task automatic start();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic send_pix(input int d);
    int n = 0;
    iPix_valid = 1'b1;
    iPix_data = 21'(d);
    exp_wr.push_back(21'(d));
    while (!oPix_ready && n < 50) begin tick(); n++; end
    if (!oPix_ready) check("pix_ready_timeout", oPix_ready, 1);
    tick();
  endtask

  task automatic send_rect(input int r);
    int n = 0;
    iRect_valid = 1'b1;
    iRect_x = 5'(rt[r][0]); iRect_y = 5'(rt[r][1]);
    iRect_w = 5'(rt[r][2]); iRect_h = 5'(rt[r][3]);
    iRect_eow = (r == 15);
    for (int k = 4; k < 8; k++) exp_addr.push_back(9'(rt[r][k]));
    while (!oRect_ready && n < 100) begin tick(); n++; end
    if (!oRect_ready) check("rect_ready_timeout", oRect_ready, 1);
    tick();
  endtask

  task automatic run_feature(input int f);
    int k;
    k = f * 8 + 3;
    exp_feat.push_back({21'(rt[k][7]), 21'(rt[k][6]), 21'(rt[k][5]), 21'(rt[k][4])});
    for (int i = 0; i < 8; i++) send_rect(f * 8 + i);
    iRect_valid = 1'b0;
  endtask

  task automatic load_window(input string tag);
    int n = 0;
    start();
    check({tag, "_err_cleared"}, oErr, 0);
    for (int i = 0; i < 400; i++) send_pix(i);
    iPix_valid = 1'b0;
    while (!oIibg_full && n < 20) begin tick(); n++; end
    check({tag, "_full_pulse"}, oIibg_full, 1);
    check({tag, "_err"}, oErr, 0);
  endtask

  initial begin
    int n;
    iReset = 1'b1; iStart = 1'b0; iPix_valid = 1'b0; iPix_data = 21'd0;
    iRect_valid = 1'b0; iRect_eow = 1'b0;
    iRect_x = 5'd0; iRect_y = 5'd0; iRect_w = 5'd0; iRect_h = 5'd0;
    repeat (3) tick();
    check("reset_outputs", all_out, 0);
    iReset = 1'b0;
    tick();

    load_window("load1");
    run_feature(0);
    check("err_feat1", oErr, 0);
    run_feature(1);
    check("err_oor_set", oErr, 1);
    n = 0;
    while (!oWin_done && n < 50) begin tick(); n++; end
    check("win_done_seen", oWin_done, 1);
    repeat (3) tick();
    check("err_sticky", oErr, 1);
    check("idle_not_busy", oBusy, 0);

    // Reset in the middle of a load, then a clean reload.
    start();
    check("err_clear_on_start", oErr, 0);
    for (int i = 0; i < 137; i++) send_pix(i);
    iPix_valid = 1'b0;
    iReset = 1'b1;
    tick();
    check("midload_reset_outputs", all_out, 0);
    iReset = 1'b0;
    tick();
    load_window("load2");

    // Reset while corner addresses are being driven, then a clean reload.
    iRect_valid = 1'b1;
    iRect_x = 5'd2; iRect_y = 5'd3; iRect_w = 5'd4; iRect_h = 5'd5; iRect_eow = 1'b0;
    exp_addr.push_back(9'd62); exp_addr.push_back(9'd66);
    exp_addr.push_back(9'd162); exp_addr.push_back(9'd166);
    n = 0;
    while (!oIibg_rdreq && n < 50) begin tick(); n++; end
    check("rdreq_seen", oIibg_rdreq, 1);
    iRect_valid = 1'b0;
    tick();
    tick();
    iReset = 1'b1;
    tick();
    check("midaddr_reset_outputs", all_out, 0);
    iReset = 1'b0;
    tick();
    load_window("load3");

    repeat (5) tick();
    check("wr_queue_empty", exp_wr.size(), 0);
    check("feat_queue_empty", exp_feat.size(), 0);
    check("full_count", full_cnt, 4);
    check("done_count", done_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
